hp_cvt_pipe: RTL and testbench
==============================

HP_CVT_PIPE -- requirements
Module: hp_cvt_pipe

Interface
REQ-001 SHALL have parameter INTn, default 32: integer input width.
REQ-002 SHALL have parameter NEXP, default 8: exponent field width.
REQ-003 SHALL have parameter NSIG, default 7: stored significand width; BIAS = 2^(NEXP-1)-1, derived, not a parameter.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1: input handshake.
REQ-007 SHALL have port in_data  input  INTn: integer operand.
REQ-008 SHALL have port in_signed  input  1: 1 = two's complement, 0 = unsigned; sampled with in_data.
REQ-009 SHALL have port in_rm  input  2: rounding mode per operand; 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 SHALL have ports out_valid output 1, out_ready input 1: output handshake.
REQ-011 SHALL have port out_data  output  NEXP+NSIG+1: {sign, exponent, significand}.
REQ-012 SHALL have ports out_inexact, out_overflow  output  1 each: per-result flags, aligned with out_data.
REQ-013 SHALL have port flag_clr  input  1: clears sticky flags.
REQ-014 SHALL have port flags_sticky  output  2: {overflow, inexact} accumulated.

Function
REQ-015 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-016 SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 leading-one detect + normalise, S3 round + pack; latency exactly 3 cycles from input transfer to out_valid with out_ready held high.
REQ-017 SHALL sustain one transfer per cycle with no bubbles when out_ready is high.
REQ-018 SHALL stall per stage: a stage advances only if the next stage is empty or advancing; in_ready = S1 empty or S1 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 SHALL hold out_data, out_inexact, out_overflow stable while out_valid && !out_ready; no result dropped, duplicated or reordered.
REQ-020 SHALL compute magnitude in INTn+1 bits so signed -2^(INTn-1) converts correctly; unsigned inputs are always positive.
REQ-021 SHALL convert zero to +0 (all bits 0), inexact=0, overflow=0.
REQ-022 SHALL set exponent = BIAS + position of leading one; round the bits below the NSIG retained bits using guard and sticky per in_rm; inexact = any discarded bit nonzero.
REQ-023 SHALL, on rounding carry-out, set significand to 0 and increment exponent.
REQ-024 SHALL flag overflow when final exponent > 2^NEXP-2: RNE, and RUP/RDN rounding away from zero, give infinity; RTZ and the other directed mode give max finite (exponent 2^NEXP-2, significand all ones); inexact=1.
REQ-025 SHALL OR result flags into flags_sticky on each output transfer; flag_clr clears both bits; flag_clr coincident with a transfer leaves exactly that transfer's flags.

Reset
REQ-026 SHALL, while rst_n low, clear all stage-valid bits, out_valid=0, out_data=0, out_inexact=0, out_overflow=0, flags_sticky=0; in_ready=1 after release.
REQ-027 SHALL discard all in-flight operands on reset mid-operation; first post-reset output is the first post-reset input.

Verification
REQ-028 SHALL pass (defaults, RNE, signed): 0 -> 0x0000 exactly 3 cycles after accept; 128 -> 0x4300; -64 -> 0xC280; all inexact=0.
REQ-029 SHALL pass 12345 -> 0x4641 inexact=1 (RNE), 0x4640 (RTZ); 2147483647 -> 0x4F00 (RNE), 0x4EFF (RTZ); 0x80000000 signed -> 0xCF00 inexact=0.
REQ-030 SHALL pass 0xFFFFFFFF: in_signed=0 RNE -> 0x4F80 inexact=1; in_signed=1 -> 0xBF80 inexact=0.
REQ-031 SHALL pass NEXP=5, NSIG=10: 2^20 -> overflow=1, 0x7C00 (RNE), 0x7BFF (RTZ); -2^20 RUP -> 0xFBFF.
REQ-032 SHALL pass backpressure: out_ready low 6 cycles, 5 inputs offered back-to-back -> exactly 3 accepted then in_ready=0, out_data stable; on release all 5 emerge in order.
REQ-033 SHALL pass sticky/reset: inexact result sets flags_sticky=01; flag_clr -> 00; rst_n pulse with 2 operands in flight -> no output for them.

Source files
------------

// File: rtl/hp_cvt_pipe.sv
// rtl/hp_cvt_pipe.sv - 3-stage integer to floating-point converter with handshakes
//
// Converts a signed or unsigned INTn-bit integer into a {sign, exponent,
// significand} float with NEXP exponent bits and NSIG stored significand bits.
// Pipeline: S1 sign/magnitude, S2 leading-one detect + normalise,
// S3 round + pack (S3 is the output register).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data              integer operand
//   in_signed            1 = two's complement, 0 = unsigned
//   in_rm                rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   out_valid/out_ready  output handshake
//   out_data             {sign, exponent, significand}
//   out_inexact          result was rounded
//   out_overflow         result exceeded the largest finite value
//   flag_clr             clears flags_sticky
//   flags_sticky         {overflow, inexact} accumulated over output transfers
module hp_cvt_pipe #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INTn-1:0]          in_data,
  input  logic                     in_signed,
  input  logic [1:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NEXP+NSIG:0]       out_data,
  output logic                     out_inexact,
  output logic                     out_overflow,
  input  logic                     flag_clr,
  output logic [1:0]               flags_sticky
);

  localparam int MW  = INTn + 1;           // magnitude width, holds -2^(INTn-1)
  localparam int PW  = $clog2(MW) + 1;     // leading-one position width
  localparam int EXW = NEXP + PW + 1;      // unbiased-plus-bias exponent, no wrap
  localparam int EW  = MW + NSIG + 1;      // normalised value padded for guard
  localparam int OW  = NEXP + NSIG + 1;

  localparam logic [EXW-1:0] BIAS = EXW'((1 << (NEXP - 1)) - 1);
  localparam logic [EXW-1:0] EMAX = EXW'((1 << NEXP) - 2);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  // Each stage accepts when it is empty or its contents move on this cycle.
  logic s1_v, s2_v;
  logic s1_take, s2_take, s3_take;

  assign s3_take  = !out_valid || out_ready;
  assign s2_take  = !s2_v || s3_take;
  assign s1_take  = !s1_v || s2_take;
  assign in_ready = s1_take;

  // ---------------- S1: sign / magnitude ----------------
  logic            in_neg;
  logic [MW-1:0]   in_ext;
  logic [MW-1:0]   in_mag;

  assign in_neg = in_signed & in_data[INTn-1];
  assign in_ext = {in_neg, in_data};
  assign in_mag = in_neg ? (~in_ext + MW'(1)) : in_ext;

  logic            s1_sign;
  logic [MW-1:0]   s1_mag;
  logic [1:0]      s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_rm   <= '0;
    end else if (s1_take) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign <= in_neg;
        s1_mag  <= in_mag;
        s1_rm   <= in_rm;
      end
    end
  end

  // ---------------- S2: leading-one detect + normalise ----------------
  logic [PW-1:0]   lo_pos;
  logic [MW-1:0]   norm;

  always_comb begin
    lo_pos = '0;
    for (int i = 0; i < MW; i++) begin
      if (s1_mag[i]) lo_pos = PW'(i);
    end
  end

  // Leading one lands in the top bit; an all-zero magnitude stays zero.
  assign norm = s1_mag << (PW'(MW - 1) - lo_pos);

  logic            s2_sign;
  logic [1:0]      s2_rm;
  logic [PW-1:0]   s2_pos;
  logic [MW-1:0]   s2_norm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_rm   <= '0;
      s2_pos  <= '0;
      s2_norm <= '0;
    end else if (s2_take) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sign <= s1_sign;
        s2_rm   <= s1_rm;
        s2_pos  <= lo_pos;
        s2_norm <= norm;
      end
    end
  end

  // ---------------- S3: round + pack ----------------
  logic [EW-1:0]   ext;
  logic [NSIG-1:0] frac;
  logic            guard, sticky, round_up, carry, to_inf;
  logic [NSIG:0]   frac_r;
  logic [EXW-1:0]  exp_r;
  logic [OW-1:0]   r_data;
  logic            r_inx, r_ovf;

  assign ext    = {s2_norm, {(NSIG + 1){1'b0}}};
  assign frac   = ext[EW-2 -: NSIG];
  assign guard  = ext[EW-2-NSIG];
  assign sticky = |ext[EW-3-NSIG:0];

  always_comb begin
    round_up = 1'b0;
    to_inf   = 1'b0;
    r_data   = '0;
    r_inx    = 1'b0;
    r_ovf    = 1'b0;
    case (s2_rm)
      RM_RNE:  round_up = guard & (sticky | frac[0]);
      RM_RDN:  round_up = s2_sign & (guard | sticky);
      RM_RUP:  round_up = !s2_sign & (guard | sticky);
      default: round_up = 1'b0;
    endcase
    frac_r = {1'b0, frac} + (NSIG + 1)'(round_up);
    carry  = frac_r[NSIG];
    // A carry out leaves frac_r's low bits all zero, which is the wanted significand.
    exp_r  = BIAS + EXW'(s2_pos) + EXW'(carry);

    if (s2_norm[MW-1]) begin
      r_inx = guard | sticky;
      if (exp_r > EMAX) begin
        r_ovf  = 1'b1;
        r_inx  = 1'b1;
        to_inf = (s2_rm == RM_RNE) || (s2_rm == RM_RUP && !s2_sign) ||
                 (s2_rm == RM_RDN && s2_sign);
        if (to_inf) r_data = {s2_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
        else        r_data = {s2_sign, EMAX[NEXP-1:0], {NSIG{1'b1}}};
      end else begin
        r_data = {s2_sign, exp_r[NEXP-1:0], frac_r[NSIG-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s3_take) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out_data     <= r_data;
        out_inexact  <= r_inx;
        out_overflow <= r_ovf;
      end
    end
  end

  // A clear coinciding with a transfer keeps only that transfer's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_sticky <= 2'b00;
    end else if (out_valid && out_ready) begin
      if (flag_clr) flags_sticky <= {out_overflow, out_inexact};
      else          flags_sticky <= flags_sticky | {out_overflow, out_inexact};
    end else if (flag_clr) begin
      flags_sticky <= 2'b00;
    end
  end

endmodule

// File: tb/tb_hp_cvt_pipe.sv
// tb/tb_hp_cvt_pipe.sv - directed self-checking bench for hp_cvt_pipe
module tb_hp_cvt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_rm, flags_sticky;
  logic [15:0] out_data;
  logic        out_inexact, out_overflow, flag_clr;

  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic [1:0]  b_in_rm, b_flags_sticky;
  logic [15:0] b_out_data;
  logic        b_out_inexact, b_out_overflow, b_flag_clr;

  hp_cvt_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_signed(in_signed), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact), .out_overflow(out_overflow),
    .flag_clr(flag_clr), .flags_sticky(flags_sticky)
  );

  hp_cvt_pipe #(.INTn(32), .NEXP(5), .NSIG(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_signed(b_in_signed), .in_rm(b_in_rm),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_inexact(b_out_inexact), .out_overflow(b_out_overflow),
    .flag_clr(b_flag_clr), .flags_sticky(b_flags_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] d, input logic sg,
                         input logic [1:0] rm, input logic [15:0] ed,
                         input logic ei, input logic eo, input logic chk_lat);
    int lat;
    @(negedge clk);
    in_data = d; in_signed = sg; in_rm = rm; in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (chk_lat) check({tag, "_lat"}, lat, 3);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_inx"}, out_inexact, ei);
    check({tag, "_ovf"}, out_overflow, eo);
  endtask

  task automatic convert_b(input string tag, input logic [31:0] d, input logic sg,
                           input logic [1:0] rm, input logic [15:0] ed,
                           input logic ei, input logic eo, input logic clr);
    int lat;
    @(negedge clk);
    b_in_data = d; b_in_signed = sg; b_in_rm = rm; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (b_out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_data"}, b_out_data, ed);
    check({tag, "_inx"}, b_out_inexact, ei);
    check({tag, "_ovf"}, b_out_overflow, eo);
    b_flag_clr = clr;
    @(posedge clk);
    #1 b_flag_clr = 1'b0;
  endtask

  logic [31:0] bp_v  [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
  logic [15:0] bp_e  [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};

  initial begin
    int sent, got, seen;
    logic acc, take;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_signed = 1'b1; in_rm = 2'b00;
    out_ready = 1'b1; flag_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_signed = 1'b1; b_in_rm = 2'b00;
    b_out_ready = 1'b1; b_flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_inx", out_inexact, 0);
    check("rst_ovf", out_overflow, 0);
    check("rst_sticky", flags_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);

    convert("zero",   32'd0,          1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
    convert("p128",   32'd128,        1'b1, 2'b00, 16'h4300, 1'b0, 1'b0, 1'b1);
    convert("m64",    -32'sd64,       1'b1, 2'b00, 16'hC280, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sticky_exact", flags_sticky, 2'b00);
    convert("x12345_rne", 32'd12345,  1'b1, 2'b00, 16'h4641, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("sticky_set", flags_sticky, 2'b01);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("sticky_clr", flags_sticky, 2'b00);
    convert("x12345_rtz", 32'd12345,  1'b1, 2'b01, 16'h4640, 1'b1, 1'b0, 1'b0);
    convert("imax_rne", 32'h7FFFFFFF, 1'b1, 2'b00, 16'h4F00, 1'b1, 1'b0, 1'b0);
    convert("imax_rtz", 32'h7FFFFFFF, 1'b1, 2'b01, 16'h4EFF, 1'b1, 1'b0, 1'b0);
    convert("imin",     32'h80000000, 1'b1, 2'b00, 16'hCF00, 1'b0, 1'b0, 1'b0);
    convert("umax",     32'hFFFFFFFF, 1'b0, 2'b00, 16'h4F80, 1'b1, 1'b0, 1'b0);
    convert("m1",       32'hFFFFFFFF, 1'b1, 2'b00, 16'hBF80, 1'b0, 1'b0, 1'b0);

    // Half-precision instance: overflow handling and flag_clr during a transfer.
    convert_b("h_ovf_rne", 32'h00100000, 1'b1, 2'b00, 16'h7C00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("h_sticky_ovf", b_flags_sticky, 2'b11);
    convert_b("h_ovf_rtz", 32'h00100000, 1'b1, 2'b01, 16'h7BFF, 1'b1, 1'b1, 1'b0);
    convert_b("h_neg_rup", 32'hFFF00000, 1'b1, 2'b11, 16'hFBFF, 1'b1, 1'b1, 1'b0);
    convert_b("h_2049_clr", 32'd2049,    1'b1, 2'b00, 16'h6800, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("h_sticky_clr_xfer", b_flags_sticky, 2'b01);

    // Backpressure: 6 stalled cycles while 5 operands are offered back-to-back.
    sent = 0; got = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_signed = 1'b1; in_rm = 2'b00;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 6) begin
        check("bp_accepted", sent, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", out_data, 16'h3F80);
        out_ready = 1'b1;
      end
      in_valid = (sent < 5);
      if (sent < 5) in_data = bp_v[sent];
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        check($sformatf("bp_out%0d", got), out_data, bp_e[got]);
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_count", got, 5);

    // Reset with two operands in flight: neither may reach the output.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd5;
    @(negedge clk);
    in_data = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_flushed", seen, 0);
    convert("post_rst", 32'd128, 1'b1, 2'b00, 16'h4300, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
